// File: rtl/bnn_act_packer.sv
// Packs retiring BNN threshold bits LSB-first into a WIDTH-bit word that
// software reads (and clears) with a single instruction.
module bnn_act_packer #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        act_valid_W,
  input  logic [31:0] BNNResult_W,
  input  logic        len_WE,
  input  logic [31:0] ExtImmW,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic [5:0]  count,
  output logic        full,
  output logic        overflow
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam logic [5:0]  WIDTH_L = 6'(WIDTH);
  localparam logic [31:0] WIDTH_X = 32'(WIDTH);

  logic [WIDTH-1:0] word_q, word_d, word_ins;
  logic [5:0]       count_q, count_d;
  logic [5:0]       pack_len_q, pack_len_d;
  logic             overflow_q, overflow_d;
  state_t           state_q, state_d;

  logic act_bit;
  logic unused_bnn_bits;
  assign act_bit         = BNNResult_W[0];
  assign unused_bnn_bits = ^BNNResult_W[31:1];

  // Current word with the incoming bit dropped into slot count_q.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ins
    assign word_ins[gi] = (count_q == 6'(gi)) ? act_bit : word_q[gi];
  end

  always_comb begin
    word_d     = word_q;
    count_d    = count_q;
    pack_len_d = pack_len_q;
    overflow_d = overflow_q;
    if (len_WE) begin
      pack_len_d = (ExtImmW == 32'd0 || ExtImmW > WIDTH_X) ? WIDTH_L : ExtImmW[5:0];
      word_d     = '0;
      count_d    = 6'd0;
      overflow_d = 1'b0;
    end else if (rd_en) begin
      // Read-and-clear; a simultaneous activation starts the next word.
      word_d     = '0;
      count_d    = 6'd0;
      overflow_d = 1'b0;
      if (act_valid_W) begin
        word_d[0] = act_bit;
        count_d   = 6'd1;
      end
    end else if (act_valid_W) begin
      if (state_q != FULL) begin
        word_d  = word_ins;
        count_d = count_q + 6'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (count_d == 6'd0)             state_d = EMPTY;
    else if (count_d == pack_len_d)  state_d = FULL;
    else                             state_d = FILLING;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q     <= '0;
      count_q    <= 6'd0;
      pack_len_q <= WIDTH_L;
      overflow_q <= 1'b0;
      state_q    <= EMPTY;
    end else begin
      word_q     <= word_d;
      count_q    <= count_d;
      pack_len_q <= pack_len_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // Bits at or above count are masked so stale data can never leak out.
  for (genvar gi = 0; gi < 32; gi++) begin : g_rd
    if (gi < WIDTH) begin : g_live
      assign rd_data[gi] = word_q[gi] & (6'(gi) < count_q);
    end else begin : g_zero
      assign rd_data[gi] = 1'b0;
    end
  end

  assign count    = count_q;
  assign full     = (state_q == FULL);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bnn_act_packer.sv
// Randomized and directed bench for bnn_act_packer against a bit-buffer model.
module tb_bnn_act_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        act_valid_W;
  logic [31:0] BNNResult_W;
  logic        len_WE;
  logic [31:0] ExtImmW;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [5:0]  count;
  logic        full;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: held bits as an integer word, a count, the pack length, sticky flag.
  logic [31:0] m_word;
  int          m_cnt;
  int          m_len;
  logic        m_ovf;

  bnn_act_packer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .act_valid_W(act_valid_W), .BNNResult_W(BNNResult_W),
    .len_WE(len_WE), .ExtImmW(ExtImmW), .rd_en(rd_en), .rd_data(rd_data),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_word = 32'd0; m_cnt = 0; m_len = 32; m_ovf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_data"}, rd_data, m_word);
    check({tag, ".count"}, 32'(count), 32'(m_cnt));
    check({tag, ".full"}, 32'(full), 32'(m_cnt == m_len));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive at negedge, apply model at posedge, check at next negedge.
  task automatic cycle(input logic act, input logic b, input logic lw,
                       input logic [31:0] imm, input logic rd, input string tag);
    act_valid_W = act;
    BNNResult_W = {$urandom} & 32'hFFFF_FFFE | 32'(b);
    len_WE      = lw;
    ExtImmW     = imm;
    rd_en       = rd;
    if (rd) check({tag, ".rd_old"}, rd_data, m_word);
    @(posedge clk);
    if (lw) begin
      m_len  = (imm == 32'd0 || imm > 32'd32) ? 32 : int'(imm);
      m_word = 32'd0; m_cnt = 0; m_ovf = 1'b0;
    end else if (rd) begin
      m_word = act ? 32'(b) : 32'd0;
      m_cnt  = act ? 1 : 0;
      m_ovf  = 1'b0;
    end else if (act) begin
      if (m_cnt < m_len) begin
        m_word = m_word | (32'(b) << m_cnt);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    act_valid_W = 1'b0; len_WE = 1'b0; rd_en = 1'b0;
    $display("txn %-10s act=%0b bit=%0b len_we=%0b imm=%0d rd=%0b -> rd_data=0x%08h count=%0d full=%0b ovf=%0b",
             tag, act, b, lw, imm, rd, rd_data, count, full, overflow);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; act_valid_W = 1'b0; BNNResult_W = 32'd0;
    len_WE = 1'b0; ExtImmW = 32'd0; rd_en = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // 32 alternating bits fill the default length.
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'((i + 1) % 2), 1'b0, 32'd0, 1'b0, "alt");
    check("alt.word", rd_data, 32'h5555_5555);
    check("alt.full", 32'(full), 32'd1);

    // Length 9, fill with ones, then one dropped bit.
    cycle(1'b0, 1'b0, 1'b1, 32'd9, 1'b0, "len9");
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, "ones");
    check("len9.word", rd_data, 32'h0000_01FF);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, "ovf");
    check("ovf.flag", 32'(overflow), 32'd1);
    check("ovf.word", rd_data, 32'h0000_01FF);

    // Read and new bit in the same cycle from FULL.
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, "rd_act");
    check("rd_act.word", rd_data, 32'h1);
    check("rd_act.cnt", 32'(count), 32'd1);

    // Length 0 and 40 both clamp to 32.
    cycle(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, "len0");
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, "fill0");
    check("len0.full", 32'(full), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 32'd40, 1'b0, "len40");
    for (int i = 0; i < 31; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, "fill40");
    check("len40.notfull", 32'(full), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, "fill40");
    check("len40.full", 32'(full), 32'd1);

    // Read from EMPTY is a no-op.
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "rd_clr");
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "rd_empty");

    // Async reset mid-fill takes effect between edges.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, "pre_rst");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst.count", 32'(count), 32'd0);
    check("arst.rd_data", rd_data, 32'd0);
    check("arst.full", 32'(full), 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);

    // len_WE wins over a simultaneous activation.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, "pre_len");
    cycle(1'b1, 1'b1, 1'b1, 32'd4, 1'b0, "len_act");
    check("len_act.cnt", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, "len4");
    check("len4.full", 32'(full), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] imm;
      r   = int'($urandom_range(0, 99));
      imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      cycle($urandom_range(0, 9) < 7, 1'($urandom), r < 5, imm,
            $urandom_range(0, 9) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bnn_act_packer.md
BNN_ACT_PACKER -- requirements
Module: bnn_act_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the packed-word width in bits; legal values 8..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port act_valid_W  input  1  a BNN instruction with threshold enabled retires this cycle.
REQ-005 SHALL have port BNNResult_W  input  32  BNN unit result; only bit 0 is used.
REQ-006 SHALL have port len_WE  input  1  writes the pack-length configuration register.
REQ-007 SHALL have port ExtImmW  input  32  pack-length write data.
REQ-008 SHALL have port rd_en  input  1  packed-word read instruction retires this cycle.
REQ-009 SHALL have port rd_data  output  32  packed word, zero-extended above WIDTH.
REQ-010 SHALL have port count  output  6  number of activation bits currently held.
REQ-011 SHALL have port full  output  1  count equals pack_len.
REQ-012 SHALL have port overflow  output  1  sticky flag: a bit was dropped because the buffer was full.

Function
REQ-013 SHALL hold registers word[WIDTH-1:0], count, pack_len and overflow, plus a state register with states EMPTY, FILLING and FULL.
REQ-014 SHALL, on len_WE, load pack_len with ExtImmW clamped to WIDTH when ExtImmW is 0 or greater than WIDTH (unsigned compare).
REQ-015 SHALL, on len_WE, also clear word, count and overflow and go to EMPTY; this has priority over all other inputs in the same cycle.
REQ-016 SHALL, when act_valid_W is high and the state is not FULL, write BNNResult_W[0] into word[count] and increment count.
REQ-017 SHALL pack bits LSB-first: the first activation goes to bit 0.
REQ-018 SHALL set the state to FULL on the edge where count reaches pack_len, FILLING when 0 < count < pack_len, and EMPTY when count is 0.
REQ-019 SHALL, when act_valid_W is high in FULL without rd_en, drop the bit, leave word and count unchanged, and set overflow.
REQ-020 SHALL drive rd_data combinationally from the current word; bits at or above count read 0.
REQ-021 SHALL, on rd_en, clear word, count and overflow at the next edge (read-and-clear).
REQ-022 SHALL, when rd_en and act_valid_W occur in the same cycle, return the old word on rd_data, then hold only the new bit at bit 0 with count = 1 and state FILLING; no overflow is set, even from FULL.
REQ-023 SHALL accept rd_en in any state; a read in EMPTY returns 0 and is otherwise a no-op.
REQ-024 SHALL drive full = (state == FULL) and count directly from registers, with no combinational path from inputs.
REQ-025 SHALL accept at most one bit per cycle and add zero cycles of latency: a bit accepted at edge N is visible on rd_data after edge N.
REQ-026 SHALL, if pack_len is lowered below count by len_WE, rely on REQ-015 clearing the buffer, so count never exceeds pack_len.

Reset
REQ-027 SHALL, on reset asserted, asynchronously set word = 0, count = 0, overflow = 0, state = EMPTY and pack_len = WIDTH.
REQ-028 SHALL, for reset asserted mid-fill, discard partial words with no pending output; reset has priority over all inputs.
REQ-029 SHALL drive outputs after reset as: rd_data = 0, count = 0, full = 0, overflow = 0.

Verification
REQ-030 SHALL cover: after reset, 32 act_valid_W pulses with bits alternating 1,0,… -> rd_data = 0x55555555, count = 32, full = 1.
REQ-031 SHALL cover: len_WE with 9, then 9 bits all 1 -> rd_data = 0x000001FF, full = 1; a 10th bit -> overflow = 1 and rd_data unchanged.
REQ-032 SHALL cover: FULL at len 9, rd_en and act_valid_W (bit 1) in the same cycle -> rd_data = 0x1FF that cycle; next cycle count = 1, rd_data = 0x1, overflow = 0.
REQ-033 SHALL cover: len_WE with 0, and separately with 40 -> pack_len = 32, buffer empty.
REQ-034 SHALL cover: 5 bits loaded, then async reset pulse between clock edges -> count = 0 and rd_data = 0 immediately, without waiting for a clock edge.
REQ-035 SHALL cover: len_WE and act_valid_W in the same cycle with 3 bits held -> count = 0, bit discarded, new pack_len applied.
